// File: rtl/ax301_segment_scanner.sv
// AX301 six-digit common-anode 7-segment scanner with frame-synchronous
// double-buffered updates and an anti-ghosting blank window per digit slot.
package ax301_peripherals_pkg;
   typedef struct packed {
      logic [7:0] segment;
      logic [5:0] sel;
   } ax301_segment_ctrl;
endpackage

module ax301_segment_scanner #(
   parameter int CLK_FREQ_HZ  = 50_000_000,
   parameter int SCAN_FREQ_HZ = 1_000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                                    clk,
   input  logic                                    nrst,
   input  logic                                    enable,
   input  logic                                    wr_en,
   input  logic [23:0]                             wr_data,
   input  logic [5:0]                              wr_dp,
   input  logic [5:0]                              wr_blank,
   output ax301_peripherals_pkg::ax301_segment_ctrl seg_ctrl,
   output logic                                    frame_done,
   output logic                                    update_pending
);

   localparam int DIV = CLK_FREQ_HZ / SCAN_FREQ_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

   generate
      if (DIV < 4) begin : g_div_too_small
         $error("ax301_segment_scanner: CLK_FREQ_HZ/SCAN_FREQ_HZ must be >= 4");
      end
      if (BLANK_CYCLES >= DIV) begin : g_blank_too_long
         $error("ax301_segment_scanner: BLANK_CYCLES must be < DIV");
      end
   endgenerate

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0:    hex7 = 7'h40;
         4'h1:    hex7 = 7'h79;
         4'h2:    hex7 = 7'h24;
         4'h3:    hex7 = 7'h30;
         4'h4:    hex7 = 7'h19;
         4'h5:    hex7 = 7'h12;
         4'h6:    hex7 = 7'h02;
         4'h7:    hex7 = 7'h78;
         4'h8:    hex7 = 7'h00;
         4'h9:    hex7 = 7'h10;
         4'hA:    hex7 = 7'h08;
         4'hB:    hex7 = 7'h03;
         4'hC:    hex7 = 7'h46;
         4'hD:    hex7 = 7'h21;
         4'hE:    hex7 = 7'h06;
         4'hF:    hex7 = 7'h0E;
         default: hex7 = 7'h7F;
      endcase
   endfunction

   logic [CW-1:0] div_q, div_d;
   logic [2:0]    idx_q, idx_d;
   logic [23:0]   act_data_q, act_data_d, sh_data_q, sh_data_d;
   logic [5:0]    act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
   logic [5:0]    act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
   logic          pend_q, pend_d;
   logic          frame_done_q;
   logic [7:0]    segment_q, segment_d;
   logic [5:0]    sel_q, sel_d;
   logic          tick, wrap, commit, dark;
   logic [3:0]    nib;

   assign tick   = enable && (div_q == DIV_LAST);
   assign wrap   = tick && (idx_q == 3'd5);
   // While dark there is no frame to protect, so a pending write lands at once.
   assign commit = pend_q && (wrap || !enable);

   // Slot divider and digit index next state.
   always_comb begin
      div_d = '0;
      idx_d = 3'd0;
      if (!enable) begin
         div_d = '0;
         idx_d = 3'd0;
      end else if (tick) begin
         div_d = '0;
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
         div_d = div_q + CW'(1);
         idx_d = idx_q;
      end
   end

   // Shadow capture and frame-boundary commit; a write on the commit edge stays pending.
   always_comb begin
      sh_data_d   = sh_data_q;
      sh_dp_d     = sh_dp_q;
      sh_blank_d  = sh_blank_q;
      act_data_d  = act_data_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      pend_d      = pend_q;
      if (commit) begin
         act_data_d  = sh_data_q;
         act_dp_d    = sh_dp_q;
         act_blank_d = sh_blank_q;
         pend_d      = 1'b0;
      end else begin
         pend_d      = pend_q;
      end
      if (wr_en) begin
         sh_data_d  = wr_data;
         sh_dp_d    = wr_dp;
         sh_blank_d = wr_blank;
         pend_d     = 1'b1;
      end else begin
         sh_data_d  = sh_data_q;
      end
   end

   // Pin values for the current slot, registered on the next edge.
   always_comb begin
      case (idx_q)
         3'd0:    nib = act_data_q[3:0];
         3'd1:    nib = act_data_q[7:4];
         3'd2:    nib = act_data_q[11:8];
         3'd3:    nib = act_data_q[15:12];
         3'd4:    nib = act_data_q[19:16];
         3'd5:    nib = act_data_q[23:20];
         default: nib = 4'h0;
      endcase
      dark = !enable || (div_q < BLANK_END) || act_blank_q[idx_q];
      if (dark) begin
         segment_d = 8'hFF;
         sel_d     = 6'h3F;
      end else begin
         segment_d = {~act_dp_q[idx_q], hex7(nib)};
         sel_d     = ~(6'd1 << idx_q);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         div_q        <= '0;
         idx_q        <= 3'd0;
         act_data_q   <= 24'h0;
         act_dp_q     <= 6'h0;
         act_blank_q  <= 6'h0;
         sh_data_q    <= 24'h0;
         sh_dp_q      <= 6'h0;
         sh_blank_q   <= 6'h0;
         pend_q       <= 1'b0;
         frame_done_q <= 1'b0;
         segment_q    <= 8'hFF;
         sel_q        <= 6'h3F;
      end else begin
         div_q        <= div_d;
         idx_q        <= idx_d;
         act_data_q   <= act_data_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         sh_data_q    <= sh_data_d;
         sh_dp_q      <= sh_dp_d;
         sh_blank_q   <= sh_blank_d;
         pend_q       <= pend_d;
         frame_done_q <= wrap;
         segment_q    <= segment_d;
         sel_q        <= sel_d;
      end
   end

   assign seg_ctrl       = {segment_q, sel_q};
   assign frame_done     = frame_done_q;
   assign update_pending = pend_q;

endmodule

// File: tb/tb_ax301_segment_scanner.sv
// Directed bench for ax301_segment_scanner with DIV=10, BLANK_CYCLES=2:
// every scanned cycle is compared against a hand-written slot/frame timeline.
module tb_ax301_segment_scanner;
   import ax301_peripherals_pkg::*;

   logic              clk = 1'b0;
   logic              nrst, enable, wr_en;
   logic [23:0]       wr_data;
   logic [5:0]        wr_dp, wr_blank;
   ax301_segment_ctrl seg_ctrl;
   logic              frame_done, update_pending;

   int passed = 0;
   int total  = 0;
   int kk     = 0;

   // Expected segment bytes, digit 5 in the top byte down to digit 0.
   localparam logic [47:0] SEG_F1 = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h88, 8'h0E};
   localparam logic [47:0] SEG_0  = {6{8'hC0}};
   localparam logic [47:0] SEG_2  = {6{8'hA4}};
   localparam logic [47:0] SEG_4  = {6{8'h99}};
   localparam logic [47:0] SEG_5  = {6{8'h92}};

   always #5 clk = ~clk;

   ax301_segment_scanner #(
      .CLK_FREQ_HZ (100),
      .SCAN_FREQ_HZ(10),
      .BLANK_CYCLES(2)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .enable        (enable),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .wr_dp         (wr_dp),
      .wr_blank      (wr_blank),
      .seg_ctrl      (seg_ctrl),
      .frame_done    (frame_done),
      .update_pending(update_pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // kk counts rising edges since enable; edge kk shows the slot state of kk-1.
   task automatic scan(input int n, input logic [47:0] segs, input logic [5:0] blank);
      int          s, i;
      logic [13:0] e;
      repeat (n) begin
         @(negedge clk);
         kk++;
         s = (kk - 1) % 10;
         i = ((kk - 1) / 10) % 6;
         if (s < 2 || blank[i]) e = {8'hFF, 6'h3F};
         else                   e = {segs[8*i +: 8], ~(6'd1 << i)};
         chk($sformatf("seg_ctrl k=%0d", kk), {18'd0, seg_ctrl}, {18'd0, e});
         chk($sformatf("frame_done k=%0d", kk), {31'd0, frame_done},
             {31'd0, ((kk - 1) % 60) == 59});
      end
   endtask

   task automatic write_scan(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl,
                             input logic [47:0] segs, input logic [5:0] cur_bl);
      wr_data  = d;
      wr_dp    = dp;
      wr_blank = bl;
      wr_en    = 1'b1;
      scan(1, segs, cur_bl);
      wr_en    = 1'b0;
   endtask

   initial begin
      nrst     = 1'b0;
      enable   = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 24'h0;
      wr_dp    = 6'h0;
      wr_blank = 6'h0;
      repeat (2) @(negedge clk);
      chk("reset seg_ctrl", {18'd0, seg_ctrl}, {18'd0, 8'hFF, 6'h3F});
      chk("reset frame_done", {31'd0, frame_done}, 32'd0);
      chk("reset pending", {31'd0, update_pending}, 32'd0);
      nrst = 1'b1;

      // Idle with scanning disabled.
      repeat (30) begin
         @(negedge clk);
         chk("idle seg_ctrl", {18'd0, seg_ctrl}, {18'd0, 8'hFF, 6'h3F});
         chk("idle frame_done", {31'd0, frame_done}, 32'd0);
      end

      // Write while disabled: pending for one cycle, then committed.
      wr_data  = 24'h1234AF;
      wr_dp    = 6'b000001;
      wr_blank = 6'b000000;
      wr_en    = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      chk("pending after write", {31'd0, update_pending}, 32'd1);
      @(negedge clk);
      chk("commit while disabled", {31'd0, update_pending}, 32'd0);
      chk("still dark", {18'd0, seg_ctrl}, {18'd0, 8'hFF, 6'h3F});

      enable = 1'b1;
      kk     = 0;
      scan(60, SEG_F1, 6'h00);

      // Mid-frame write: old digits hold until the 5->0 wrap.
      scan(25, SEG_F1, 6'h00);
      write_scan(24'h000000, 6'h00, 6'h00, SEG_F1, 6'h00);
      chk("pending mid-frame", {31'd0, update_pending}, 32'd1);
      scan(33, SEG_F1, 6'h00);
      chk("pending before wrap", {31'd0, update_pending}, 32'd1);
      scan(1, SEG_F1, 6'h00);
      chk("pending cleared at wrap", {31'd0, update_pending}, 32'd0);
      scan(60, SEG_0, 6'h00);

      // Two writes in one frame: only the last is ever shown.
      scan(10, SEG_0, 6'h00);
      write_scan(24'h111111, 6'h00, 6'h00, SEG_0, 6'h00);
      scan(9, SEG_0, 6'h00);
      write_scan(24'h222222, 6'h00, 6'h00, SEG_0, 6'h00);
      chk("pending after 2nd write", {31'd0, update_pending}, 32'd1);
      scan(39, SEG_0, 6'h00);
      chk("pending after commit 2", {31'd0, update_pending}, 32'd0);
      scan(60, SEG_2, 6'h00);

      // Blank digit 5; then a write landing exactly on the commit edge.
      scan(10, SEG_2, 6'h00);
      write_scan(24'h222222, 6'h00, 6'b100000, SEG_2, 6'h00);
      scan(49, SEG_2, 6'h00);
      scan(40, SEG_2, 6'b100000);
      write_scan(24'h444444, 6'h00, 6'h00, SEG_2, 6'b100000);
      scan(18, SEG_2, 6'b100000);
      write_scan(24'h555555, 6'h00, 6'h00, SEG_2, 6'b100000);
      chk("pending kept on commit edge", {31'd0, update_pending}, 32'd1);
      scan(60, SEG_4, 6'h00);
      chk("pending after late commit", {31'd0, update_pending}, 32'd0);

      // Asynchronous reset in the digit 3 slot.
      scan(33, SEG_5, 6'h00);
      #2 nrst = 1'b0;
      #1;
      chk("async reset seg_ctrl", {18'd0, seg_ctrl}, {18'd0, 8'hFF, 6'h3F});
      chk("async reset frame_done", {31'd0, frame_done}, 32'd0);
      chk("async reset pending", {31'd0, update_pending}, 32'd0);
      repeat (3) @(negedge clk);
      chk("held reset seg_ctrl", {18'd0, seg_ctrl}, {18'd0, 8'hFF, 6'h3F});
      nrst = 1'b1;
      kk   = 0;
      scan(30, SEG_0, 6'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ax301_segment_scanner.md
Name: ax301_segment_scanner

Overview:
Time-multiplexed driver for the AX301 six-digit common-anode 7-segment display. It accepts a 24-bit hex value, a decimal-point mask and a blank mask through a write strobe, then scans one digit per slot. It drives the board pins through an ax301_peripherals_pkg::ax301_segment_ctrl output. Writes are double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
CLK_FREQ_HZ, 50_000_000, input clock frequency.
SCAN_FREQ_HZ, 1_000, digit-slot rate. DIV = CLK_FREQ_HZ/SCAN_FREQ_HZ; DIV must be >= 4 (elaboration assertion).
BLANK_CYCLES, 2, anti-ghosting cycles at the start of each slot with all digits deselected. Must be < DIV.

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
enable  input  1  scan enable; low = display dark
wr_en  input  1  single-cycle write strobe
wr_data  input  24  digit i = wr_data[4i+3:4i], i = 0..5
wr_dp  input  6  decimal point on for digit i when bit i = 1
wr_blank  input  6  digit i dark for its whole slot when bit i = 1
seg_ctrl  output  14  ax301_segment_ctrl: .segment[7:0] active-low (bit7 = dp, bits 6:0 = g..a); .sel[5:0] active-low digit select
frame_done  output  1  one-cycle pulse at each 5->0 digit wrap
update_pending  output  1  shadow holds a write not yet committed

Behaviour:
- Reset (nrst low, async):
  - seg_ctrl.segment = 8'hFF; seg_ctrl.sel = 6'h3F.
  - frame_done = 0; update_pending = 0.
  - div_cnt = 0; idx = 0.
  - Active and shadow data/dp/blank registers all cleared to 0.
- Write: wr_en latches wr_data, wr_dp and wr_blank into the shadow and sets update_pending next cycle. A later write before commit overwrites the shadow (last write wins).
- div_cnt counts 0..DIV-1 and wraps. tick = (div_cnt == DIV-1).
- On tick: idx = (idx == 5) ? 0 : idx + 1.
- When idx wraps 5->0:
  - frame_done pulses on that same edge.
  - If update_pending, shadow is copied to active and update_pending clears on the same edge.
  - If wr_en coincides with the commit edge, the new write goes into the shadow and update_pending stays 1; the old shadow content is the one committed.
- Output stage is registered, computed each cycle from the current idx, div_cnt and active registers (1-cycle latency):
  - If !enable, or div_cnt < BLANK_CYCLES, or active_blank[idx]: sel = 6'h3F, segment = 8'hFF.
  - Otherwise: sel = ~(6'b1 << idx); segment = {~active_dp[idx], hex7(active_data[idx])}.
- hex7, active-low encoding of bits 6:0:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- enable low:
  - div_cnt and idx are held at 0; frame_done stays 0.
  - A pending update is committed immediately on the next edge, so the first frame after re-enable shows the latest data.
  - The first slot after enable rises is digit 0, starting with its blanking window.
- At most one sel bit is low at any cycle; sel is never low while segment is mid-transition between digits.
- Mid-operation reset returns every output to the reset values asynchronously. Scanning restarts at digit 0 after release.

Test Plan:
Use CLK_FREQ_HZ=100, SCAN_FREQ_HZ=10 (DIV=10), BLANK_CYCLES=2 throughout.
- Reset then idle with enable=0 -> seg_ctrl stays {8'hFF, 6'h3F}; frame_done never pulses.
- Write wr_data=24'h12_34AF, dp=6'b000001, blank=0; enable=1:
  - digit 0 slot: sel=6'h3E, segment=8'h0E (F with dp on);
  - digit 1 slot: sel=6'h3D, segment=8'h88 (A);
  - frame period = 60 cycles; each slot shows 2 dark cycles, then 8 driven cycles.
- With scan running, write 24'h000000 mid-frame -> update_pending=1; display keeps the old values until the 5->0 wrap; at the frame_done edge pending clears; the next digit 0 shows segment 8'hC0.
- Two writes in one frame (24'h111111, then 24'h222222) -> only 2 (segment 8'hA4) is ever displayed; 1 never appears.
- wr_blank=6'b100000 -> the digit 5 slot keeps sel=6'h3F for all 10 cycles; frame_done timing is unchanged.
- Assert nrst low during the digit 3 slot -> outputs go to {8'hFF, 6'h3F} without waiting for a clock edge; after release, the first driven sel is 6'h3E at cycle 3.
